// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: parity modes,
// frame state encoding, board baud default and the parity helper.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // 50 MHz board clock at 9600 baud
   localparam int unsigned BPS_DEFAULT = 5208;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Zero padding of narrow words does not change the XOR reduction.
   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BPS_MAX-1 while enabled, held at zero otherwise.
// tick marks the last cycle of each bit period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned BPS_MAX = BPS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = $clog2(BPS_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(BPS_MAX - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear when disabled, wrap on the last cycle of the period.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready intake, optional parity,
// one or two stop bits and registered busy/done status.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned BPS_MAX   = BPS_DEFAULT,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = PAR_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (BPS_MAX < 2) begin : g_bad_bps
      $error("uart_tx_frame: BPS_MAX must be >= 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY > PAR_ODD) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int unsigned BCW     = $clog2(BIT_MAX);
   localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
   localparam logic HAS_PAR = (PARITY != PAR_NONE);
   localparam logic ODD_PAR = (PARITY == PAR_ODD);

   uart_state_e          state_q,   state_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 par_q,     par_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 tx_q,      tx_d;
   logic                 ready_q,   ready_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic                 baud_en_s;
   logic                 baud_tick_s;

   assign baud_en_s = (state_q != ST_IDLE);

   uart_baud_cnt #(
      .BPS_MAX (BPS_MAX)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (baud_en_s),
      .tick (baud_tick_s)
   );

   // Frame sequencing; tx is computed one edge ahead so the pin is registered.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_valid && ready_q) begin
               shift_d   = tx_data;
               par_d     = parity_bit(9'(tx_data), ODD_PAR);
               bit_cnt_d = {BCW{1'b0}};
               state_d   = ST_START;
               tx_d      = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end else begin
               tx_d      = 1'b1;
            end
         end
         ST_START: begin
            if (baud_tick_s) begin
               state_d   = ST_DATA;
               bit_cnt_d = {BCW{1'b0}};
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            end else begin
               tx_d      = 1'b0;
            end
         end
         ST_DATA: begin
            if (baud_tick_s) begin
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = {BCW{1'b0}};
                  if (HAS_PAR) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               end
            end else begin
               bit_cnt_d = bit_cnt_q;
            end
         end
         ST_PARITY: begin
            if (baud_tick_s) begin
               state_d   = ST_STOP;
               bit_cnt_d = {BCW{1'b0}};
               tx_d      = 1'b1;
            end else begin
               tx_d      = par_q;
            end
         end
         ST_STOP: begin
            if (baud_tick_s) begin
               if (bit_cnt_q == STOP_LAST) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = {BCW{1'b0}};
                  ready_d   = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
               tx_d = 1'b1;
            end else begin
               tx_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = {BCW{1'b0}};
            tx_d      = 1'b1;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= {DATA_BITS{1'b0}};
         par_q     <= 1'b0;
         bit_cnt_q <= {BCW{1'b0}};
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share one stimulus stream and
// are compared cycle by cycle against a timeline model of the frame rules.
module tb_uart_tx_frame;

   localparam int BPS  = 4;
   localparam int WMAX = 320;

   int cfg_db   [4] = '{8, 8, 8, 7};
   int cfg_par  [4] = '{0, 1, 2, 0};
   int cfg_stop [4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [3:0] tx_w, ready_w, busy_w, done_w;

   logic       rst_stim   [WMAX];
   logic       valid_stim [WMAX];
   logic [7:0] data_stim  [WMAX];
   // packed as {tx, ready, busy, done}
   logic [3:0] cap  [WMAX][4];
   logic [3:0] expv [WMAX][4];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.BPS_MAX(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
   uart_tx_frame #(.BPS_MAX(BPS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
   uart_tx_frame #(.BPS_MAX(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
   uart_tx_frame #(.BPS_MAX(BPS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
      .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

   task automatic clear_stim(input int len);
      for (int c = 0; c < len; c++) begin
         rst_stim[c]   = 1'b0;
         valid_stim[c] = 1'b0;
         data_stim[c]  = 8'h00;
      end
      rst_stim[0] = 1'b1;
   endtask

   task automatic run(input int len);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         rst      = rst_stim[c];
         tx_valid = valid_stim[c];
         tx_data  = data_stim[c];
         @(posedge clk);
         #1;
         for (int d = 0; d < 4; d++)
            cap[c][d] = {tx_w[d], ready_w[d], busy_w[d], done_w[d]};
      end
      @(negedge clk);
      rst      = 1'b0;
      tx_valid = 1'b0;
   endtask

   // Timeline model: a frame accepted at edge s occupies edges s..s+L-1 with
   // frame bit k/BPS on the line, and ends at edge s+L with a done pulse.
   task automatic build_expected(input int len);
      int   start [4];
      bit   inf   [4];
      logic fb    [4][16];
      for (int d = 0; d < 4; d++) begin
         start[d] = 0;
         inf[d]   = 1'b0;
         for (int i = 0; i < 16; i++) fb[d][i] = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
         for (int d = 0; d < 4; d++) begin
            int nb, flen, db;
            logic [8:0] w;
            logic p;
            db   = cfg_db[d];
            nb   = 1 + db + ((cfg_par[d] != 0) ? 1 : 0) + cfg_stop[d];
            flen = nb * BPS;
            if (rst_stim[c]) begin
               inf[d] = 1'b0;
               expv[c][d] = 4'b1100;
            end else if (inf[d]) begin
               if (c - start[d] == flen) begin
                  inf[d] = 1'b0;
                  expv[c][d] = 4'b1101;
               end else begin
                  expv[c][d] = {fb[d][(c - start[d]) / BPS], 3'b010};
               end
            end else if (valid_stim[c]) begin
               w = 9'(data_stim[c]) & ((9'd1 << db) - 9'd1);
               p = ^w;
               if (cfg_par[d] == 2) p = ~p;
               for (int i = 0; i < 16; i++) begin
                  if (i == 0) fb[d][i] = 1'b0;
                  else if (i <= db) fb[d][i] = w[i-1];
                  else if ((i == db + 1) && (cfg_par[d] != 0)) fb[d][i] = p;
                  else fb[d][i] = 1'b1;
               end
               start[d] = c;
               inf[d] = 1'b1;
               expv[c][d] = 4'b0010;
            end else begin
               expv[c][d] = 4'b1100;
            end
         end
      end
   endtask

   task automatic test_reset();
      clear_stim(6);
      build_expected(6);
      run(6);
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[0][d] !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_state dut%0d got %b exp 1100", d, cap[0][d]);
         end
      end
      for (int c = 0; c < 6; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL reset_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_8n1_a5();
      logic [9:0] pat;
      int busy_cnt;
      pat = {1'b1, 8'hA5, 1'b0};
      clear_stim(50);
      valid_stim[1] = 1'b1;
      data_stim[1]  = 8'hA5;
      build_expected(50);
      run(50);
      for (int j = 0; j < 10; j++) begin
         for (int k = 0; k < BPS; k++) begin
            vectors++;
            if (cap[1 + BPS*j + k][0][3] !== pat[j]) begin
               miscompares++;
               $display("FAIL a5_bit%0d cyc%0d got %b exp %b", j, 1 + BPS*j + k, cap[1 + BPS*j + k][0][3], pat[j]);
            end
         end
      end
      busy_cnt = 0;
      for (int c = 0; c < 50; c++) if (cap[c][0][1]) busy_cnt++;
      vectors++;
      if (busy_cnt !== 40) begin
         miscompares++;
         $display("FAIL a5_busy_len got %0d exp 40", busy_cnt);
      end
      vectors++;
      if (cap[41][0][0] !== 1'b1 || cap[40][0][0] !== 1'b0 || cap[42][0][0] !== 1'b0) begin
         miscompares++;
         $display("FAIL a5_done_at41 got %b%b%b exp 010", cap[40][0][0], cap[41][0][0], cap[42][0][0]);
      end
      for (int c = 0; c < 50; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL a5_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_parity();
      clear_stim(52);
      valid_stim[1] = 1'b1;
      data_stim[1]  = 8'h07;
      build_expected(52);
      run(52);
      vectors++;
      if (cap[37][1][3] !== 1'b1) begin
         miscompares++;
         $display("FAIL parity_even got %b exp 1", cap[37][1][3]);
      end
      vectors++;
      if (cap[37][2][3] !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_odd got %b exp 0", cap[37][2][3]);
      end
      for (int d = 1; d < 3; d++) begin
         vectors++;
         if (cap[45][d] !== 4'b1101 || cap[44][d][1] !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_len44 dut%0d got %b exp 1101", d, cap[45][d]);
         end
      end
      for (int c = 0; c < 52; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL parity_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] w2;
      w2 = 7'h34;
      clear_stim(100);
      for (int c = 1; c <= 50; c++) begin
         valid_stim[c] = 1'b1;
         data_stim[c]  = (c == 1) ? 8'h12 : 8'h34;
      end
      build_expected(100);
      run(100);
      vectors++;
      if (cap[41][3] !== 4'b1101 || cap[42][3] !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_gap got %b %b exp 1101 0010", cap[41][3], cap[42][3]);
      end
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if (cap[42 + BPS*(1+i)][3][3] !== w2[i]) begin
            miscompares++;
            $display("FAIL b2b_word2_bit%0d got %b exp %b", i, cap[42 + BPS*(1+i)][3][3], w2[i]);
         end
      end
      for (int c = 0; c < 100; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL b2b_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_hold_data();
      clear_stim(60);
      for (int c = 1; c <= 39; c++) begin
         valid_stim[c] = 1'b1;
         data_stim[c]  = (c == 1) ? 8'hFF : 8'h00;
      end
      build_expected(60);
      run(60);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (cap[5 + BPS*i][0][3] !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_bit%0d got %b exp 1", i, cap[5 + BPS*i][0][3]);
         end
      end
      vectors++;
      if (cap[40][0][2] !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_ready got %b exp 0", cap[40][0][2]);
      end
      for (int c = 0; c < 60; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL hold_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dn;
      clear_stim(80);
      valid_stim[1]  = 1'b1;
      data_stim[1]   = 8'($urandom);
      rst_stim[20]   = 1'b1;
      valid_stim[25] = 1'b1;
      data_stim[25]  = 8'($urandom);
      build_expected(80);
      run(80);
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[20][d] !== 4'b1100) begin
            miscompares++;
            $display("FAIL rstmid_abort dut%0d got %b exp 1100", d, cap[20][d]);
         end
         dn = 0;
         for (int c = 0; c < 80; c++) if (cap[c][d][0]) dn++;
         vectors++;
         if (dn !== 1) begin
            miscompares++;
            $display("FAIL rstmid_done_count dut%0d got %0d exp 1", d, dn);
         end
      end
      for (int c = 0; c < 80; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL rstmid_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_reset_valid();
      clear_stim(60);
      for (int c = 0; c <= 4; c++) begin
         rst_stim[c]   = (c <= 3);
         valid_stim[c] = 1'b1;
         data_stim[c]  = 8'($urandom);
      end
      build_expected(60);
      run(60);
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[3][d] !== 4'b1100 || cap[4][d] !== 4'b0010) begin
            miscompares++;
            $display("FAIL rstvalid_accept dut%0d got %b %b exp 1100 0010", d, cap[3][d], cap[4][d]);
         end
      end
      for (int c = 0; c < 60; c++) for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cap[c][d] !== expv[c][d]) begin
            miscompares++;
            $display("FAIL rstvalid_trace dut%0d cyc%0d got %b exp %b", d, c, cap[c][d], expv[c][d]);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         clear_stim(300);
         for (int c = 1; c < 300; c++) begin
            valid_stim[c] = ($urandom_range(0, 3) == 0);
            data_stim[c]  = 8'($urandom);
            rst_stim[c]   = ($urandom_range(0, 149) == 0);
         end
         build_expected(300);
         run(300);
         for (int c = 0; c < 300; c++) for (int d = 0; d < 4; d++) begin
            vectors++;
            if (cap[c][d] !== expv[c][d]) begin
               miscompares++;
               $display("FAIL random%0d_trace dut%0d cyc%0d got %b exp %b", it, d, c, cap[c][d], expv[c][d]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_8n1_a5();
      test_parity();
      test_back_to_back();
      test_hold_data();
      test_reset_mid();
      test_reset_valid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
